// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_pkg
// Description : Shared types for the handshaked sequential ALU. Holds the
//               opcode and FSM state encodings and the iteration-count helper
//               used by the multiplier and the divider.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

    // Iteration count of the default 8-bit build. The core derives its own
    // count from WIDTH through iter_count() so every width stays consistent.
    localparam int c_default_iter = 8;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_DIV = 3'b011,
        OP_OR  = 3'b100,
        OP_MUL = 3'b101,
        OP_XOR = 3'b110,
        OP_LTU = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    // One partial product / quotient bit per cycle: iterations equal width.
    function automatic int iter_count(input int width);
        return width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_divider
// Description : Iterative restoring divider, one quotient bit per cycle.
//               The first bit is produced on the start edge itself, so done
//               pulses for one cycle WIDTH cycles after start, with quotient
//               final and held until the next start. Built only when
//               ALU_SEQ_DIV_EN is defined.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               start         - load dividend/divisor and begin
//               dividend      - unsigned dividend
//               divisor       - unsigned divisor (caller guarantees non-zero)
//               busy          - iterations in progress
//               done          - one-cycle pulse, quotient valid
//               quotient      - unsigned quotient
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient
);

    localparam int                 c_cnt_w = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_div;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_busy;
    logic               r_done;

    logic [WIDTH-1:0]   w_rem_in;
    logic [WIDTH-1:0]   w_quo_in;
    logic [WIDTH-1:0]   w_div_in;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH+1:0]   w_trial;
    logic               w_fits;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_quo_next;
    logic               w_unused;

    // On start the step works straight from the operands, saving one cycle.
    assign w_rem_in = start ? '0       : r_rem;
    assign w_quo_in = start ? dividend : r_quo;
    assign w_div_in = start ? divisor  : r_div;

    // Shift the next dividend bit into the partial remainder and try the
    // subtraction; a clear sign bit means the divisor fits.
    assign w_shift    = {w_rem_in, w_quo_in[WIDTH-1]};
    assign w_trial    = {1'b0, w_shift} - {2'b00, w_div_in};
    assign w_fits     = ~w_trial[WIDTH+1];
    // A restored or reduced remainder is always below the divisor, so the
    // top bit of the difference is never needed.
    assign w_rem_next = w_fits ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quo_next = {w_quo_in[WIDTH-2:0], w_fits};
    assign w_unused   = w_trial[WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_rem  <= w_rem_next;
                r_quo  <= w_quo_next;
                r_div  <= divisor;
                r_cnt  <= c_cnt_w'(1);
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_rem <= w_rem_next;
                r_quo <= w_quo_next;
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == c_last) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign quotient = r_quo;

endmodule
`default_nettype wire

// File: rtl/alu_seq_core.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_core
// Description : Handshaked sequential ALU. One operation at a time enters on
//               a valid/ready port; the registered result and flags leave on
//               a valid/ready port. Logic/add ops finish in one cycle, MUL
//               (inline shift-add) and DIV (alu_seq_divider) take WIDTH
//               iteration cycles.
//               Build option ALU_SEQ_DIV_EN: when defined the divider is
//               built; otherwise op 011 is unsupported and returns err=1.
// Ports       : clk, rst                 - clock, sync active-high reset
//               in_valid/in_ready        - request handshake
//               op, a, b                 - opcode and unsigned operands
//               out_valid/out_ready      - result handshake
//               result, zero, carry, err - registered result and flags
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_core
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             err
);

    localparam int                 c_iter  = iter_count(WIDTH);
    localparam int                 c_cnt_w = $clog2(c_iter);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(c_iter - 1);

    state_t             r_state;
    state_t             w_state_next;
    op_t                w_op;
    logic               w_accept;
    logic               w_sc_op;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH-1:0]   w_sc_result;
    logic               w_sc_carry;
    logic               w_sc_err;

    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [c_cnt_w-1:0] r_cnt;
    logic [2*WIDTH-1:0] w_acc_next;
    logic               w_mul_last;

    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               r_carry;
    logic               r_err;

    assign w_op      = op_t'(op);
    assign in_ready  = (r_state == IDLE) && !rst;
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (r_state == DONE);

`ifdef ALU_SEQ_DIV_EN
    logic             w_div_start;
    logic             w_div_busy;
    logic             w_div_done;
    logic [WIDTH-1:0] w_div_quo;

    assign w_div_start = w_accept && (w_op == OP_DIV) && (b != '0);

    alu_seq_divider #(
        .WIDTH    (WIDTH)
    ) u_divider (
        .clk      (clk),
        .rst      (rst),
        .start    (w_div_start),
        .dividend (a),
        .divisor  (b),
        .busy     (w_div_busy),
        .done     (w_div_done),
        .quotient (w_div_quo)
    );

    // Divide by zero never enters the divider; it completes like a logic op.
    assign w_sc_op = (w_op != OP_MUL) && !((w_op == OP_DIV) && (b != '0));
`else
    assign w_sc_op = (w_op != OP_MUL);
`endif

    // ------------------------------------------------------------------
    // Single-cycle results, computed from the live operands and captured
    // on the accepting edge.
    // ------------------------------------------------------------------
    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        w_sc_result = '0;
        w_sc_carry  = 1'b0;
        w_sc_err    = 1'b0;
        case (w_op)
            OP_ADD: begin
                w_sc_result = w_sum[WIDTH-1:0];
                w_sc_carry  = w_sum[WIDTH];
            end
            OP_SUB: begin
                // Bit WIDTH of the wide difference is the borrow (a < b).
                w_sc_result = w_diff[WIDTH-1:0];
                w_sc_carry  = w_diff[WIDTH];
            end
            OP_AND: w_sc_result = a & b;
            OP_OR:  w_sc_result = a | b;
            OP_XOR: w_sc_result = a ^ b;
            OP_LTU: w_sc_result = WIDTH'(a < b);
`ifdef ALU_SEQ_DIV_EN
            OP_DIV: begin
                // Only reaches the outputs for b == 0.
                w_sc_result = '1;
                w_sc_err    = 1'b1;
            end
`else
            OP_DIV: w_sc_err = 1'b1;
`endif
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    assign w_mul_last = (r_cnt == c_last);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_op == OP_MUL) begin
                        w_state_next = MUL;
                    end else if (w_sc_op) begin
                        w_state_next = DONE;
                    end else begin
                        w_state_next = DIV;
                    end
                end
            end
            MUL: begin
                if (w_mul_last) begin
                    w_state_next = DONE;
                end
            end
            DIV: begin
`ifdef ALU_SEQ_DIV_EN
                if (w_div_done && !w_div_busy) begin
                    w_state_next = DONE;
                end
`else
                w_state_next = IDLE;
`endif
            end
            DONE: begin
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operand capture, shift-add multiplier, output registers.
    // Outputs only change on entry to DONE, so they hold through backpressure.
    // ------------------------------------------------------------------
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_carry  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_acc    <= '0;
                        r_mcand  <= {{WIDTH{1'b0}}, a};
                        r_mplier <= b;
                        r_cnt    <= '0;
                        if (w_sc_op) begin
                            r_result <= w_sc_result;
                            r_zero   <= (w_sc_result == '0);
                            r_carry  <= w_sc_carry;
                            r_err    <= w_sc_err;
                        end
                    end
                end
                MUL: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_mul_last) begin
                        r_result <= w_acc_next[WIDTH-1:0];
                        r_zero   <= (w_acc_next[WIDTH-1:0] == '0);
                        r_carry  <= |w_acc_next[2*WIDTH-1:WIDTH];
                        r_err    <= 1'b0;
                    end
                end
                DIV: begin
`ifdef ALU_SEQ_DIV_EN
                    if (w_div_done) begin
                        r_result <= w_div_quo;
                        r_zero   <= (w_div_quo == '0);
                        r_carry  <= 1'b0;
                        r_err    <= 1'b0;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    assign result = r_result;
    assign zero   = r_zero;
    assign carry  = r_carry;
    assign err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq_core
// Description : Directed self-checking bench for alu_seq_core (WIDTH=8).
//               Expected values are hand-computed; the DIV vectors follow the
//               ALU_SEQ_DIV_EN build option.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq_core;

    localparam logic [2:0] c_add = 3'b000;
    localparam logic [2:0] c_sub = 3'b001;
    localparam logic [2:0] c_and = 3'b010;
    localparam logic [2:0] c_div = 3'b011;
    localparam logic [2:0] c_or  = 3'b100;
    localparam logic [2:0] c_mul = 3'b101;
    localparam logic [2:0] c_xor = 3'b110;
    localparam logic [2:0] c_ltu = 3'b111;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       zero;
    logic       carry;
    logic       err;

    int n_checks = 0;
    int n_errors = 0;

    alu_seq_core #(
        .WIDTH     (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .carry     (carry),
        .err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Issue one op, scramble the inputs right after the accept edge, measure
    // accept-to-out_valid latency, check the result, then hand it off.
    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [7:0] x, input logic [7:0] y,
                          input logic [7:0] exp_res, input logic exp_z,
                          input logic exp_c, input logic exp_e, input int exp_lat);
        int lat;
        check({tag, ".in_ready"}, in_ready, 1);
        op       = o;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op       = c_add;
        a        = 8'h5A;
        b        = 8'hC3;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".latency"}, lat, exp_lat);
        check({tag, ".result"}, result, exp_res);
        check({tag, ".zero"}, zero, exp_z);
        check({tag, ".carry"}, carry, exp_c);
        check({tag, ".err"}, err, exp_e);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, ".ov_after"}, out_valid, 0);
        check({tag, ".ir_after"}, in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 3'b000;
        a         = 8'd0;
        b         = 8'd0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst.in_ready", in_ready, 0);
        check("rst.out_valid", out_valid, 0);
        check("rst.result", result, 0);
        check("rst.flags", {zero, carry, err}, 3'b000);
        rst = 1'b0;
        #1;
        check("rst.in_ready_after", in_ready, 1);

        // out_ready while idle has no effect
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("idle_ordy.out_valid", out_valid, 0);
        check("idle_ordy.in_ready", in_ready, 1);

        //     tag         op     a      b      result z     c     e     lat
        run_op("add_ovf",  c_add, 8'd200, 8'd100, 8'd44,  1'b0, 1'b1, 1'b0, 1);
        run_op("add_zero", c_add, 8'd0,   8'd0,   8'd0,   1'b1, 1'b0, 1'b0, 1);
        run_op("sub_brw",  c_sub, 8'd5,   8'd7,   8'd254, 1'b0, 1'b1, 1'b0, 1);
        run_op("sub_pos",  c_sub, 8'd7,   8'd5,   8'd2,   1'b0, 1'b0, 1'b0, 1);
        run_op("ltu_t",    c_ltu, 8'd5,   8'd7,   8'd1,   1'b0, 1'b0, 1'b0, 1);
        run_op("ltu_f",    c_ltu, 8'd7,   8'd7,   8'd0,   1'b1, 1'b0, 1'b0, 1);
        run_op("and",      c_and, 8'hF0,  8'h3C,  8'h30,  1'b0, 1'b0, 1'b0, 1);
        run_op("or",       c_or,  8'hF0,  8'h0F,  8'hFF,  1'b0, 1'b0, 1'b0, 1);
        run_op("xor_zero", c_xor, 8'hAA,  8'hAA,  8'h00,  1'b1, 1'b0, 1'b0, 1);
        run_op("mul_255",  c_mul, 8'd15,  8'd17,  8'd255, 1'b0, 1'b0, 1'b0, 9);
        run_op("mul_256",  c_mul, 8'd16,  8'd16,  8'd0,   1'b1, 1'b1, 1'b0, 9);
        run_op("mul_max",  c_mul, 8'd255, 8'd255, 8'd1,   1'b0, 1'b1, 1'b0, 9);
`ifdef ALU_SEQ_DIV_EN
        run_op("div_28",   c_div, 8'd200, 8'd7,   8'd28,  1'b0, 1'b0, 1'b0, 9);
        run_op("div_by1",  c_div, 8'd255, 8'd1,   8'd255, 1'b0, 1'b0, 1'b0, 9);
        run_op("div_small",c_div, 8'd7,   8'd200, 8'd0,   1'b1, 1'b0, 1'b0, 9);
        run_op("div_by0",  c_div, 8'd9,   8'd0,   8'd255, 1'b0, 1'b0, 1'b1, 1);
`else
        run_op("div_unsup",c_div, 8'd200, 8'd7,   8'd0,   1'b1, 1'b0, 1'b1, 1);
        run_op("div_by0",  c_div, 8'd9,   8'd0,   8'd0,   1'b1, 1'b0, 1'b1, 1);
`endif

        // Backpressure: result held, new request ignored until handoff
        check("bp.in_ready", in_ready, 1);
        op       = c_add;
        a        = 8'd3;
        b        = 8'd4;
        in_valid = 1'b1;
        @(posedge clk); #1;
        op = c_xor;
        a  = 8'h0F;
        b  = 8'hF0;
        check("bp.out_valid", out_valid, 1);
        check("bp.result", result, 7);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp.hold_result", result, 7);
            check("bp.hold_in_ready", in_ready, 0);
            check("bp.hold_out_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp.release_ov", out_valid, 0);
        check("bp.release_ir", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp.second_ov", out_valid, 1);
        check("bp.second_result", result, 8'hFF);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp.second_done", out_valid, 0);

        // Reset in the 4th iteration cycle aborts the long op
`ifdef ALU_SEQ_DIV_EN
        op = c_div;
        a  = 8'd200;
        b  = 8'd7;
`else
        op = c_mul;
        a  = 8'd15;
        b  = 8'd17;
`endif
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("midrst.busy_ov", out_valid, 0);
        rst = 1'b1;
        #1;
        check("midrst.in_ready_in_rst", in_ready, 0);
        @(posedge clk); #1;
        check("midrst.out_valid", out_valid, 0);
        check("midrst.result", result, 0);
        check("midrst.flags", {zero, carry, err}, 3'b000);
        rst = 1'b0;
        #1;
        check("midrst.in_ready", in_ready, 1);
        run_op("post_rst_add", c_add, 8'd1, 8'd1, 8'd2, 1'b0, 1'b0, 1'b0, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_seq_core.md
# alu_seq_core

Parametrised, handshaked successor to the 8-bit tt_um ALU. It accepts one operation at a time through a valid/ready input port and returns a registered result with flags through a valid/ready output port. Logic ops complete in one cycle; multiply and divide run iteratively over WIDTH cycles. It sits between the TinyTapeout pin wrapper (or any producer) and downstream consumers, replacing the free-running combinational-then-register ALU.

## Interface
- WIDTH, 8: operand and result width in bits; legal range 4..32.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operation request.
- in_ready  output  1  core can accept a request; high only in IDLE and not in reset.
- op  input  3  operation code.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- out_valid  output  1  result, zero, carry and err are valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  operation result.
- zero  output  1  result equals 0.
- carry  output  1  add carry-out, subtract borrow, or multiply overflow.
- err  output  1  divide by zero, or an unsupported op.

## Operation
- Opcodes: 000 ADD, 001 SUB, 010 AND, 011 DIV, 100 OR, 101 MUL, 110 XOR, 111 LTU (result = 1 if a<b, else 0).
- Accept: a request is accepted on a clock edge where in_valid and in_ready are both high. At that edge, op, a and b are captured into internal registers, and later input changes have no effect.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE with accepted MUL goes to MUL; accepted DIV with b≠0 goes to DIV; any other accepted op goes to DONE.
  - MUL and DIV go to DONE after exactly WIDTH iteration cycles.
  - DONE goes to IDLE on out_valid and out_ready.
- ADD/SUB: computed at WIDTH+1 bits. result is the low WIDTH bits. carry is bit WIDTH, which is the borrow for SUB (set when a<b).
- MUL: shift-add, one partial product per cycle into a 2·WIDTH accumulator. result is the low WIDTH bits. carry is set if the high WIDTH bits are nonzero.
- DIV: restoring division, one quotient bit per cycle. result is the quotient; the remainder is discarded.
- DIV with b=0 goes straight to DONE with result all-ones, err=1 and carry=0.
- Logic ops and LTU: carry=0, err=0.
- zero is computed from the final result for every op.
- Outputs result, zero, carry and err are registered. They are held stable for the whole time out_valid is high.

## Timing
- Reset values: out_valid=0, result=0, zero=0, carry=0, err=0, state IDLE. in_ready=0 while rst is high and 1 in the first cycle after.
- Accept in cycle N:
  - Single-cycle ops and DIV-by-zero: out_valid high in cycle N+1.
  - MUL and DIV: out_valid high in cycle N+WIDTH+1.
- Backpressure: DONE holds indefinitely while out_ready is low. in_ready stays low, and in_valid is ignored.
- Completion: on the edge where out_valid and out_ready are both high, the next cycle is IDLE with in_ready=1 and out_valid=0. No accept happens in the same cycle as a result handoff, so the maximum throughput is one op per 2 cycles.
- Reset mid-operation: rst high at any edge, including during MUL or DIV, aborts the operation and forces the reset values. No partial result is ever presented.
- out_ready while out_valid is low has no effect.

## Configuration
- ALU_SEQ_DIV_EN defined: the DIV state and alu_seq_divider are built as described above.
- ALU_SEQ_DIV_EN undefined: no divider hardware is built, and op 011 is unsupported. It completes in one cycle (DONE at N+1) with result=0, zero=1, carry=0, err=1.
- All other ops behave identically in both builds.

## Structure
- Package alu_seq_pkg holds:
  - the op_t enum (8 codes above);
  - the state_t enum (IDLE, MUL, DIV, DONE);
  - the localparam for the iteration count (= WIDTH, passed through by the core).
- One sub-module, alu_seq_divider: a WIDTH-parametrised iterative restoring divider with start/busy/done and quotient output. It is instantiated only under ALU_SEQ_DIV_EN.
- The multiplier and the single-cycle ops stay inline in alu_seq_core.

## Test plan
All scenarios use WIDTH=8 unless stated otherwise.
- ADD a=200, b=100 → result=44, carry=1, zero=0, out_valid one cycle after accept.
- SUB a=5, b=7 → result=254, carry=1. LTU a=5, b=7 → result=1.
- MUL 15×17 → result=255, carry=0. MUL 16×16 → result=0, carry=1, zero=1. In both cases out_valid is first high 9 cycles after accept.
- DIV 200/7 → result=28, err=0 at accept+9. DIV 9/0 → result=255, err=1 at accept+1. Without ALU_SEQ_DIV_EN, DIV 200/7 → result=0, err=1 at accept+1.
- Backpressure: hold out_ready low for 5 cycles after out_valid with in_valid high and new operands → result stays stable, in_ready=0, and no second accept occurs. Release → IDLE next cycle, then the new op is accepted.
- Reset mid-DIV: assert rst in the 4th iteration cycle → next cycle out_valid=0 and all outputs are 0; the cycle after, in_ready=1. A fresh ADD 1+1 then returns result=2.
